// File: rtl/capture_sequencer.sv
// capture_sequencer: collects a frame of ADC samples into a small buffer, then
// hands them one at a time, oldest first, to the Arduino word writer.
// Build option: define CAPTURE_CONTINUOUS_EN to make a finished frame restart
// collection with the same latched limit until abort or reset.
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | waiting for start with a non-zero limit
// COLLECT | adc_req high, storing each adc_valid sample
// TX_LOAD | fetch the next sample into tx_data and launch the writer
// TX_WAIT | waiting for the writer to report tx_done
// DONE    | one-cycle done strobe, then back to IDLE (or COLLECT)
module capture_sequencer #(
  parameter int DATA_W = 12,
  parameter int DEPTH  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [4:0]        limit,
  output logic              adc_req,
  input  logic              adc_valid,
  input  logic [DATA_W-1:0] adc_data,
  output logic              tx_start,
  output logic [DATA_W-1:0] tx_data,
  input  logic              tx_done,
  output logic              busy,
  output logic              done
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // One extra bit so a count can hold DEPTH itself (a full buffer).
  localparam int CNT_W = PTR_W + 1;

  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] COLLECT = 3'd1;
  localparam logic [2:0] TX_LOAD = 3'd2;
  localparam logic [2:0] TX_WAIT = 3'd3;
  localparam logic [2:0] DONE    = 3'd4;

  logic [2:0]        state;
  logic [CNT_W-1:0]  lim;
  logic [CNT_W-1:0]  lim_sel;
  logic [CNT_W-1:0]  collected;
  logic [CNT_W-1:0]  sent;
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [DATA_W-1:0] sample_mem [DEPTH];

  // Frames longer than the buffer are clipped to the buffer size.
  always_comb begin
    lim_sel = CNT_W'(limit);
    if (32'(limit) > 32'(DEPTH)) lim_sel = CNT_W'(DEPTH);
  end

  assign adc_req = (state == COLLECT);
  assign busy    = (state != IDLE);
  assign done    = (state == DONE);

  // Sample storage; contents are don't-care after reset, so no reset here.
  always_ff @(posedge clk) begin
    if (!abort && state == COLLECT && adc_valid) sample_mem[wr_ptr] <= adc_data;
  end

  // Sequencer state, pointers, counters and the registered writer interface.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      lim       <= '0;
      collected <= '0;
      sent      <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      tx_start  <= 1'b0;
      tx_data   <= '0;
    end else begin
      tx_start <= 1'b0;
      if (abort) begin
        // Abort beats every other event; counters are rebuilt at the next start.
        state <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (start && limit != 5'd0) begin
              lim       <= lim_sel;
              collected <= '0;
              sent      <= '0;
              wr_ptr    <= '0;
              rd_ptr    <= '0;
              state     <= COLLECT;
            end
          end
          COLLECT: begin
            if (adc_valid) begin
              wr_ptr    <= wr_ptr + PTR_ONE;
              collected <= collected + CNT_ONE;
              if (collected + CNT_ONE == lim) state <= TX_LOAD;
            end
          end
          TX_LOAD: begin
            tx_data  <= sample_mem[rd_ptr];
            tx_start <= 1'b1;
            rd_ptr   <= rd_ptr + PTR_ONE;
            state    <= TX_WAIT;
          end
          TX_WAIT: begin
            if (tx_done) begin
              sent <= sent + CNT_ONE;
              if (sent + CNT_ONE == lim) state <= DONE;
              else                       state <= TX_LOAD;
            end
          end
          DONE: begin
`ifdef CAPTURE_CONTINUOUS_EN
            collected <= '0;
            sent      <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            state     <= COLLECT;
`else
            state     <= IDLE;
`endif
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_capture_sequencer.sv
// Bench for capture_sequencer: expected tx_data words are queued as each frame
// is set up, a negedge monitor pops and compares on every tx_start, and a
// writer model answers tx_start with tx_done after a programmable delay.
module tb_capture_sequencer;

  localparam int DATA_W = 12;
  localparam int DEPTH  = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              start = 1'b0;
  logic              abort = 1'b0;
  logic [4:0]        limit = 5'd0;
  logic              adc_req;
  logic              adc_valid = 1'b0;
  logic [DATA_W-1:0] adc_data = '0;
  logic              tx_start;
  logic [DATA_W-1:0] tx_data;
  logic              tx_done;
  logic              tx_done_w = 1'b0;
  logic              tx_done_s = 1'b0;
  logic              busy;
  logic              done;

  assign tx_done = tx_done_w | tx_done_s;

  int checks = 0;
  int failures = 0;
  int tx_cnt = 0;
  int done_cnt = 0;
  int wr_delay = 40;
  int frame_len = 4;
  int word_idx = 0;
  bit wr_en = 1'b1;
  bit gap_chk = 1'b0;
  bit prev_done = 1'b0;
  logic [DATA_W-1:0] held;
  logic [DATA_W-1:0] exp_q [$];
  int base_tx;
  int base_done;

  capture_sequencer #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .abort    (abort),
    .limit    (limit),
    .adc_req  (adc_req),
    .adc_valid(adc_valid),
    .adc_data (adc_data),
    .tx_start (tx_start),
    .tx_data  (tx_data),
    .tx_done  (tx_done),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_start(input logic [4:0] lim);
    limit = lim;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic feed(input logic [DATA_W-1:0] d);
    int t;
    t = 0;
    while (!adc_req && t < 300) begin
      tick();
      t++;
    end
    check("adc_req_wait", 32'(adc_req), 32'd1);
    adc_valid = 1'b1;
    adc_data  = d;
    tick();
    adc_valid = 1'b0;
  endtask

  task automatic wait_done(input int target, input int maxc);
    int t;
    t = 0;
    while (done_cnt < target && t < maxc) begin
      tick();
      t++;
    end
    check("done_wait", 32'(done_cnt >= target), 32'd1);
  endtask

  task automatic wait_tx(input int target, input int maxc);
    int t;
    t = 0;
    while (tx_cnt < target && t < maxc) begin
      tick();
      t++;
    end
    check("tx_wait", 32'(tx_cnt >= target), 32'd1);
  endtask

  // Scoreboard monitor: compare every launched word and follow up every done.
  initial begin
    forever begin
      @(negedge clk);
      if (tx_start) begin
        tx_cnt++;
        check("tx_expected", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) check("tx_data", 32'(tx_data), 32'(exp_q.pop_front()));
      end
      if (prev_done) begin
`ifdef CAPTURE_CONTINUOUS_EN
        check("adc_req_after_done", 32'(adc_req), 32'd1);
`else
        check("idle_after_done", 32'(busy), 32'd0);
`endif
      end
      if (done) done_cnt++;
      prev_done = done;
    end
  end

  // Arduino writer model with latency checks on the DUT's reaction.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (gap_chk) begin
        check("tx_gap_2cyc", 32'(tx_start), 32'd1);
        gap_chk = 1'b0;
      end
      if (wr_en && tx_start) begin
        held = tx_data;
        repeat (wr_delay) begin
          @(posedge clk);
          #1;
        end
        if (wr_en) begin
          check("tx_data_hold", 32'(tx_data), 32'(held));
          tx_done_w = 1'b1;
          @(posedge clk);
          #1;
          tx_done_w = 1'b0;
          word_idx++;
          if (word_idx % frame_len == 0) begin
            check("done_1cyc", 32'(done), 32'd1);
          end else begin
            check("no_early_start", 32'(tx_start), 32'd0);
            gap_chk = 1'b1;
          end
        end
      end
    end
  end

  initial begin
    #300000;
    failures++;
    $display("FAIL watchdog timeout");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    tick(3);
    check("reset_outputs", 32'({busy, adc_req, tx_start, done, tx_data}), 32'd0);
    rst = 1'b1;
    tick(2);

`ifdef CAPTURE_CONTINUOUS_EN
    // Continuous frames of two samples, stopped by abort.
    wr_delay = 5; frame_len = 2; word_idx = 0; wr_en = 1'b1;
    base_tx = tx_cnt; base_done = done_cnt;
    for (int f = 0; f < 3; f++) begin
      exp_q.push_back(12'(12'h600 + 2 * f));
      exp_q.push_back(12'(12'h601 + 2 * f));
    end
    pulse_start(5'd2);
    for (int f = 0; f < 3; f++) begin
      feed(12'(12'h600 + 2 * f));
      feed(12'(12'h601 + 2 * f));
    end
    wait_done(base_done + 3, 400);
    check("cont_collecting", 32'(adc_req), 32'd1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("cont_abort_idle", 32'(busy), 32'd0);
    tick(3);
    check("cont_tx_count", 32'(tx_cnt - base_tx), 32'd6);
    check("cont_done_count", 32'(done_cnt - base_done), 32'd3);
    check("cont_queue_empty", 32'(exp_q.size()), 32'd0);
`else
    // Four-sample frame, slow writer; start while busy must be ignored.
    wr_delay = 40; frame_len = 4; word_idx = 0; wr_en = 1'b1;
    base_tx = tx_cnt; base_done = done_cnt;
    exp_q.push_back(12'h111); exp_q.push_back(12'h222);
    exp_q.push_back(12'h333); exp_q.push_back(12'h444);
    pulse_start(5'd4);
    check("busy_1cyc", 32'(busy), 32'd1);
    check("adc_req_collect", 32'(adc_req), 32'd1);
    feed(12'h111);
    tick();
    feed(12'h222);
    feed(12'h333);
    tick(2);
    feed(12'h444);
    check("adc_req_off_at_limit", 32'(adc_req), 32'd0);
    limit = 5'd4;
    start = 1'b1;
    tick(5);
    start = 1'b0;
    wait_done(base_done + 1, 600);
    tick(2);
    check("f4_tx_count", 32'(tx_cnt - base_tx), 32'd4);
    check("f4_done_count", 32'(done_cnt - base_done), 32'd1);
    check("f4_busy_after", 32'(busy), 32'd0);
    check("f4_queue_empty", 32'(exp_q.size()), 32'd0);

    // limit above DEPTH is clipped to a full buffer.
    wr_delay = 3; frame_len = 16; word_idx = 0;
    base_tx = tx_cnt; base_done = done_cnt;
    for (int i = 0; i < 16; i++) exp_q.push_back(12'(12'h500 + i));
    pulse_start(5'd20);
    for (int i = 0; i < 16; i++) feed(12'(12'h500 + i));
    check("f20_adc_req_off", 32'(adc_req), 32'd0);
    adc_valid = 1'b1;
    adc_data  = 12'hFFF;
    tick();
    adc_valid = 1'b0;
    wait_done(base_done + 1, 600);
    tick(2);
    check("f20_tx_count", 32'(tx_cnt - base_tx), 32'd16);
    check("f20_done_count", 32'(done_cnt - base_done), 32'd1);
    check("f20_queue_empty", 32'(exp_q.size()), 32'd0);

    // limit=0 never leaves IDLE.
    pulse_start(5'd0);
    check("lim0_busy", 32'(busy), 32'd0);
    tick(3);
    check("lim0_idle", 32'({busy, adc_req}), 32'd0);

    // Abort after the second launch, then a clean one-sample frame.
    wr_delay = 40; frame_len = 4; word_idx = 0;
    base_tx = tx_cnt; base_done = done_cnt;
    exp_q.push_back(12'hA01); exp_q.push_back(12'hA02);
    pulse_start(5'd4);
    feed(12'hA01); feed(12'hA02); feed(12'hA03); feed(12'hA04);
    wait_tx(base_tx + 2, 300);
    tick(3);
    wr_en = 1'b0;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_idle", 32'({busy, adc_req}), 32'd0);
    tick(60);
    check("abort_tx_count", 32'(tx_cnt - base_tx), 32'd2);
    check("abort_no_done", 32'(done_cnt - base_done), 32'd0);
    check("abort_queue_empty", 32'(exp_q.size()), 32'd0);
    wr_en = 1'b1; frame_len = 1; word_idx = 0; wr_delay = 4;
    exp_q.push_back(12'hB05);
    pulse_start(5'd1);
    feed(12'hB05);
    wait_done(base_done + 1, 200);
    tick(2);
    check("after_abort_tx_count", 32'(tx_cnt - base_tx), 32'd3);
    check("after_abort_done", 32'(done_cnt - base_done), 32'd1);

    // Asynchronous reset while waiting on the writer, then stray strobes in IDLE.
    wr_delay = 40; frame_len = 2; word_idx = 0;
    base_tx = tx_cnt; base_done = done_cnt;
    exp_q.push_back(12'hC01);
    pulse_start(5'd2);
    feed(12'hC01); feed(12'hC02);
    wait_tx(base_tx + 1, 200);
    tick(3);
    check("pre_rst_busy", 32'(busy), 32'd1);
    wr_en = 1'b0;
    #2 rst = 1'b0;
    #1 check("rst_async_outputs", 32'({busy, adc_req, tx_start, done, tx_data}), 32'd0);
    #3 rst = 1'b1;
    tick();
    adc_valid = 1'b1; adc_data = 12'h777; tx_done_s = 1'b1;
    tick();
    adc_valid = 1'b0; tx_done_s = 1'b0;
    tick(2);
    check("stray_idle", 32'({busy, adc_req}), 32'd0);
    tick(50);
    check("rst_tx_count", 32'(tx_cnt - base_tx), 32'd1);
    check("rst_no_done", 32'(done_cnt - base_done), 32'd0);
    wr_en = 1'b1; frame_len = 1; word_idx = 0; wr_delay = 2;
    exp_q.push_back(12'hD0D);
    pulse_start(5'd1);
    feed(12'hD0D);
    wait_done(base_done + 1, 200);
    tick(2);
    check("post_rst_frame_tx", 32'(tx_cnt - base_tx), 32'd2);
    check("post_rst_queue_empty", 32'(exp_q.size()), 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
